// File: rtl/seq_cmp_pkg.sv
// Shared types and sizing for the sequential comparator front-end sequencer.
package seq_cmp_pkg;

    localparam int DEFAULT_WIDTH = 32;

    // Counter must reach WIDTH itself, so one bit more than $clog2(WIDTH).
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

    localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_FLUSH = 3'd3,
        S_CAPT  = 3'd4,
        S_HOLD  = 3'd5
    } state_e;

    function automatic logic is_onehot3(input logic [2:0] v);
        return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
    endfunction

endpackage

// File: rtl/seq_cmp_cycle_counter.sv
// Serial-compare cycle counter: clears on clr_i, counts on en_i, flags WIDTH-1.
module seq_cmp_cycle_counter
    import seq_cmp_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CW    = CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [CW-1:0] cnt_q;

    // Count register; clear has priority over enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + CW'(1);
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign tc_o = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/seq_cmp_controller.sv
// Front-end sequencer for the sequential unsigned comparator.
// Optional one-hot result check (err port) when SEQ_CMP_ONEHOT_CHK_EN is defined.
module seq_cmp_controller
    import seq_cmp_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] cmp_a,
    output logic [WIDTH-1:0] cmp_b,
    output logic             cmp_ip,
    output logic             cmp_op,
    input  logic             cmp_l,
    input  logic             cmp_e,
    input  logic             cmp_g,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_l,
    output logic             out_e,
    output logic             out_g,
    output logic             busy
`ifdef SEQ_CMP_ONEHOT_CHK_EN
    ,
    output logic             err
`endif
);

    localparam int CW = cnt_width(WIDTH);

    state_e           state_q;
    logic [WIDTH-1:0] cmp_a_q, cmp_b_q;
    logic             cmp_ip_q, cmp_op_q;
    logic             out_valid_q, out_l_q, out_e_q, out_g_q;
    logic             in_ready_q, busy_q;
    logic             cnt_tc_s;
`ifdef SEQ_CMP_ONEHOT_CHK_EN
    logic             err_q;
`endif

    seq_cmp_cycle_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (state_q == S_LOAD),
        .en_i  (state_q == S_RUN),
        .tc_o  (cnt_tc_s)
    );

    // Sequencer FSM; every output is a register set on the transition into its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cmp_a_q     <= '0;
            cmp_b_q     <= '0;
            cmp_ip_q    <= 1'b0;
            cmp_op_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_l_q     <= 1'b0;
            out_e_q     <= 1'b0;
            out_g_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
`ifdef SEQ_CMP_ONEHOT_CHK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        cmp_a_q    <= in_a;
                        cmp_b_q    <= in_b;
                        cmp_ip_q   <= 1'b1;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    cmp_ip_q <= 1'b0;
                    state_q  <= S_RUN;
                end
                S_RUN: begin
                    if (cnt_tc_s) begin
                        cmp_op_q <= 1'b1;
                        state_q  <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    cmp_op_q <= 1'b0;
                    state_q  <= S_CAPT;
                end
                S_CAPT: begin
                    out_l_q     <= cmp_l;
                    out_e_q     <= cmp_e;
                    out_g_q     <= cmp_g;
                    out_valid_q <= 1'b1;
                    state_q     <= S_HOLD;
`ifdef SEQ_CMP_ONEHOT_CHK_EN
                    if (!is_onehot3({cmp_l, cmp_e, cmp_g})) begin
                        err_q <= 1'b1;
                    end
`endif
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    cmp_ip_q    <= 1'b0;
                    cmp_op_q    <= 1'b0;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign cmp_a     = cmp_a_q;
    assign cmp_b     = cmp_b_q;
    assign cmp_ip    = cmp_ip_q;
    assign cmp_op    = cmp_op_q;
    assign out_valid = out_valid_q;
    assign out_l     = out_l_q;
    assign out_e     = out_e_q;
    assign out_g     = out_g_q;
`ifdef SEQ_CMP_ONEHOT_CHK_EN
    assign err       = err_q;
`endif

endmodule

// File: tb/tb_seq_cmp_controller.sv
// Directed bench: controller driving a behavioural MSB-first serial comparator.
module tb_seq_cmp_controller;

    localparam int W   = 32;
    localparam int LAT = W + 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic [W-1:0] cmp_a, cmp_b;
    logic         cmp_ip, cmp_op;
    logic         cmp_l, cmp_e, cmp_g;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         out_l, out_e, out_g;
    logic         busy;
`ifdef SEQ_CMP_ONEHOT_CHK_EN
    logic         err;
`endif

    int tests = 0;
    int fails = 0;
    logic overlap_seen = 1'b0;
    logic stub_en = 1'b0;

    always #5 clk = ~clk;

    seq_cmp_controller #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .cmp_a     (cmp_a),
        .cmp_b     (cmp_b),
        .cmp_ip    (cmp_ip),
        .cmp_op    (cmp_op),
        .cmp_l     (cmp_l),
        .cmp_e     (cmp_e),
        .cmp_g     (cmp_g),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_l     (out_l),
        .out_e     (out_e),
        .out_g     (out_g),
        .busy      (busy)
`ifdef SEQ_CMP_ONEHOT_CHK_EN
        ,
        .err       (err)
`endif
    );

    // Serial comparator model: load on ip, decide MSB-first, publish on op.
    logic [W-1:0] sa, sb;
    logic         lt, gt, rl, re, rg;
    always @(posedge clk) begin
        if (rst) begin
            sa <= '0; sb <= '0; lt <= 1'b0; gt <= 1'b0;
            rl <= 1'b0; re <= 1'b0; rg <= 1'b0;
        end else if (cmp_ip) begin
            sa <= cmp_a; sb <= cmp_b; lt <= 1'b0; gt <= 1'b0;
        end else if (cmp_op) begin
            rl <= lt; rg <= gt; re <= !lt && !gt;
        end else begin
            if (!lt && !gt) begin
                if (sa[W-1] && !sb[W-1]) gt <= 1'b1;
                else if (!sa[W-1] && sb[W-1]) lt <= 1'b1;
            end
            sa <= sa << 1;
            sb <= sb << 1;
        end
    end

    // Stub mode forces a non-one-hot result (l and g together).
    assign cmp_l = stub_en ? 1'b1 : rl;
    assign cmp_e = stub_en ? 1'b0 : re;
    assign cmp_g = stub_en ? 1'b1 : rg;

    always @(negedge clk) begin
        if (cmp_ip && cmp_op) overlap_seen <= 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept a pair, measure latency, hold for 'hold' cycles, then release.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] exp_leg, input int hold);
        int lat;
        check("idle_ready", in_ready, 1);
        in_a = a; in_b = b; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("accept_ready_low", in_ready, 0);
        check("accept_busy", busy, 1);
        check("load_ip", cmp_ip, 1);
        check("opnd_a", cmp_a, a);
        check("opnd_b", cmp_b, b);
        lat = 0;
        for (int n = 1; n <= 60; n++) begin
            tick();
            if (out_valid) begin
                lat = n;
                break;
            end
        end
        check("latency", lat, LAT);
        check("result_leg", {out_l, out_e, out_g}, exp_leg);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", out_valid, 1);
            check("hold_ready", in_ready, 0);
            check("hold_leg", {out_l, out_e, out_g}, exp_leg);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("release_valid", out_valid, 0);
        check("release_ready", in_ready, 1);
        check("release_busy", busy, 0);
        check("leg_kept", {out_l, out_e, out_g}, exp_leg);
    endtask

    initial begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_outs", {out_valid, out_l, out_e, out_g, cmp_ip, cmp_op}, 0);
        check("rst_opnd", {cmp_a, cmp_b}, 0);

        do_op(32'd50, 32'd50, 3'b010, 0);
        do_op(32'h0000_0001, 32'hFFFF_FFFF, 3'b100, 0);
        do_op(32'h8000_0000, 32'h7FFF_FFFF, 3'b001, 10);

        // Reset mid-RUN: accept edge plus 11 edges leaves the counter at 10.
        in_a = 32'd3; in_b = 32'd4; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 11; i++) tick();
        check("midrun_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_ready", in_ready, 1);
        check("midrst_busy", busy, 0);
        check("midrst_outs", {out_valid, out_l, out_e, out_g, cmp_ip, cmp_op}, 0);
        check("midrst_opnd", {cmp_a, cmp_b}, 0);
        do_op(32'd7, 32'd9, 3'b100, 0);

`ifdef SEQ_CMP_ONEHOT_CHK_EN
        check("err_clean", err, 0);
        stub_en = 1'b1;
        do_op(32'd5, 32'd5, 3'b101, 0);
        stub_en = 1'b0;
        check("err_set", err, 1);
        do_op(32'd5, 32'd6, 3'b100, 0);
        check("err_sticky", err, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("err_rst", err, 0);
`endif

        check("ip_op_overlap", overlap_seen, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_cmp_controller.md
Name: seq_cmp_controller

Overview:
Front-end sequencer for the team's sequential unsigned comparator.
- Accepts operand pairs over a valid/ready handshake and holds them stable on the comparator operand bus.
- Drives the comparator's load (ip) and output-strobe (op) controls through the full WIDTH-cycle serial compare.
- Captures the l/e/g result and returns it over a valid/ready handshake.
- Sits directly upstream of the comparator: it produces the comparator's a, b, ip and op; it consumes the comparator's l, e and g.

Parameters:
- WIDTH, 32, operand width; also the number of serial compare cycles.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  controller can accept a pair; high only in IDLE.
- in_a  input  WIDTH  operand A, unsigned.
- in_b  input  WIDTH  operand B, unsigned.
- cmp_a  output  WIDTH  to comparator a; registered, held for the whole operation.
- cmp_b  output  WIDTH  to comparator b; registered, held for the whole operation.
- cmp_ip  output  1  to comparator ip (load strobe).
- cmp_op  output  1  to comparator op (result strobe).
- cmp_l, cmp_e, cmp_g  input  1 each  from comparator.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_l, out_e, out_g  output  1 each  captured result: A<B, A==B, A>B.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, rst=1 at an edge), from any state including mid-operation:
  - state goes to IDLE; counter clears to 0.
  - cmp_a, cmp_b, cmp_ip, cmp_op, out_valid, out_l, out_e, out_g all go to 0.
  - in_ready=1 and busy=0 in the cycle after the reset edge.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, register in_a→cmp_a and in_b→cmp_b, then go to LOAD.
  - LOAD: cmp_ip=1 for exactly one cycle, then go to RUN with counter=0.
  - RUN: cmp_ip=0, cmp_op=0. Counter increments each cycle. After WIDTH cycles (counter==WIDTH-1 at the edge), go to FLUSH.
  - FLUSH: cmp_op=1 for exactly one cycle, then go to CAPT.
  - CAPT: register cmp_l/e/g into out_l/e/g, set out_valid=1, then go to HOLD.
  - HOLD: out_valid=1 and out_l/e/g stable. On out_ready, clear out_valid and go to IDLE.
- Latency: out_valid rises WIDTH+3 rising edges after the accepting edge (35 cycles for WIDTH=32).
- in_valid is ignored while busy; in_ready is never asserted combinationally from out_ready.
  - Back-to-back throughput is therefore one pair per WIDTH+5 cycles minimum.
- out_l/e/g keep their last value after the handshake until the next CAPT.
- Counter width: $clog2(WIDTH)+1 bits; wrap-around is impossible by construction.
- WIDTH=1 is legal: RUN lasts one cycle.
- cmp_ip and cmp_op are never high in the same cycle.

Optional Feature:
- Macro: SEQ_CMP_ONEHOT_CHK_EN.
- Defined:
  - Adds output port err (1 bit).
  - err is set in CAPT if {cmp_l,cmp_e,cmp_g} is not exactly one-hot.
  - err is sticky and cleared only by rst.
  - The result is still captured and presented normally.
- Undefined: the err port and its logic are absent; the interface is otherwise identical.

Decomposition:
- Package seq_cmp_pkg holds:
  - the state enum: IDLE, LOAD, RUN, FLUSH, CAPT, HOLD;
  - the default WIDTH constant;
  - the counter-width localparam.
- One natural sub-module: seq_cmp_cycle_counter, with clear, enable and terminal-count-at-WIDTH-1 output.
- The FSM, operand registers and result registers stay in the top module.

Test Plan:
- Bench structure: the controller drives the team's sequential unsigned comparator, which feeds cmp_l/e/g back to the controller.
- 1. Assert rst one cycle, then send a=50, b=50. Expect in_ready=0 next cycle, out_valid high 35 edges after accept, and out_e=1, out_l=0, out_g=0.
- 2. Send a=0x00000001, b=0xFFFFFFFF. Expect out_l=1 only.
- 3. Send a=0x80000000, b=0x7FFFFFFF. Expect out_g=1 only (unsigned ordering).
- 4. Hold out_ready=0 for 10 cycles after out_valid. Expect out_valid and outputs stable and in_ready=0 throughout. Then pulse out_ready: expect out_valid=0 and in_ready=1 in the next cycle.
- 5. Assert rst while in RUN at counter=10. Expect IDLE next cycle with all outputs 0. Then send a=7, b=9: expect out_l=1 after 35 cycles.
- 6. With SEQ_CMP_ONEHOT_CHK_EN defined, use a stub comparator returning l=1, g=1. Expect err=1 after CAPT, err still 1 after a following valid compare, and err=0 only after rst.
